// File: rtl/alu64_issue_ctrl_if.sv
// Request, ALU-side and response signals of the 64-bit ALU issue/capture sequencer.
// slave is the sequencer's view; master is the requester/ALU/consumer side.
interface alu64_issue_ctrl_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned OP_W   = 2;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_cin;
  logic [OP_W-1:0]   req_op;
  logic              req_chain;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_cin;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_s;
  logic              alu_cout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_s;
  logic              rsp_cout;

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_op, req_chain,
    output req_ready,
    output alu_a, alu_b, alu_cin, alu_op,
    input  alu_s, alu_cout,
    output rsp_valid, rsp_s, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_cin, req_op, req_chain,
    input  req_ready,
    input  alu_a, alu_b, alu_cin, alu_op,
    output alu_s, alu_cout,
    input  rsp_valid, rsp_s, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/alu64_issue_ctrl.sv
// Issues one request at a time onto the ripple ALU inputs, holds them for a settle
// window, then captures sum/carry into a response register with optional carry chaining.
module alu64_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  alu64_issue_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               accept_c;
  logic               capture_c;

  assign accept_c  = (state_q == IDLE) && bus.req_valid;
  assign capture_c = (state_q == SETTLE) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    bus.req_ready = 1'b1;
      DONE:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand launch, settle countdown and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_cin  <= 1'b0;
      bus.alu_op   <= '0;
      bus.rsp_s    <= '0;
      bus.rsp_cout <= 1'b0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
    end else if (accept_c) begin
      bus.alu_a   <= bus.req_a;
      bus.alu_b   <= bus.req_b;
      bus.alu_op  <= bus.req_op;
      bus.alu_cin <= bus.req_chain ? carry_q : bus.req_cin;
      cnt_q       <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (capture_c) begin
      bus.rsp_s    <= bus.alu_s;
      bus.rsp_cout <= bus.alu_cout;
      carry_q      <= bus.alu_cout;
    end else if (state_q == SETTLE) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: doc/alu64_issue_ctrl.md
# alu64_issue_ctrl

Issue/capture sequencer that sits directly in front of and behind the 64-bit ripple ALU (`alu64bit`). It accepts one operation request at a time over a valid/ready handshake and registers the operands onto the ALU inputs. It holds those inputs stable for a fixed settle window sized for the 64-bit ripple carry, then captures `s`/`cout` into a response register. It also supports carry chaining across consecutive requests, so that 128-bit and wider adds run as multiple 64-bit passes.

## Interface
- `SETTLE_CYCLES`, 4: cycles the ALU inputs are held stable before capture; legal range 1..255.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_a`  in  64  operand a.
- `req_b`  in  64  operand b.
- `req_cin`  in  1  carry in; used when `req_chain`=0.
- `req_op`  in  2  ALU operation code; passed through unmodified.
- `req_chain`  in  1  1: use stored carry (previous `cout`) instead of `req_cin`.
- `alu_a`, `alu_b`  out  64  registered ALU operands.
- `alu_cin`  out  1  registered ALU carry in.
- `alu_op`  out  2  registered ALU op.
- `alu_s`  in  64  ALU result.
- `alu_cout`  in  1  ALU carry out.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_s`  out  64  captured result.
- `rsp_cout`  out  1  captured carry out.

## Operation
- States: IDLE, SETTLE, DONE. `req_ready` = (state==IDLE). `rsp_valid` = (state==DONE).
- **IDLE:** on `req_valid`, the accept edge does the following:
  - `alu_a`<=`req_a`, `alu_b`<=`req_b`, `alu_op`<=`req_op`.
  - `alu_cin`<=(`req_chain` ? `carry_q` : `req_cin`).
  - `cnt`<=`SETTLE_CYCLES`-1; next state SETTLE.
- **SETTLE:** each edge:
  - if `cnt`==0: `rsp_s`<=`alu_s`, `rsp_cout`<=`alu_cout`, `carry_q`<=`alu_cout`; next state DONE.
  - otherwise `cnt`<=`cnt`-1.
- **DONE:** hold `rsp_*`; on `rsp_ready` go to IDLE.
- Single outstanding operation.
  - `req_*` inputs are ignored outside IDLE.
  - `alu_*` outputs change only on an accept edge; they stay held through SETTLE, DONE and IDLE until the next accept.
- `carry_q` is internal and updated only at capture. A chained request after reset uses `carry_q`=0.
- No arithmetic in this block; widths pass straight through, and `req_op` is never decoded.
- `cnt` width is 8 bits.

## Timing
- **Reset:** with `rst` high at an edge:
  - state=IDLE; `alu_a`=`alu_b`=0, `alu_cin`=0, `alu_op`=0.
  - `rsp_s`=0, `rsp_cout`=0, `carry_q`=0, `cnt`=0.
  - `rsp_valid`=0, `req_ready`=1.
  - `rst` has priority over every other event.
- **Reset mid-operation** (SETTLE or DONE): the operation is aborted, no response is issued, and `carry_q` is cleared.
- **Latency:** request accepted at edge N.
  - ALU inputs valid after N.
  - Capture at edge N+`SETTLE_CYCLES`; `rsp_valid` high from then on.
  - The ALU sees stable inputs for exactly `SETTLE_CYCLES` cycles before sampling.
- **Throughput:** response accepted at edge M returns the block to IDLE; the next request is accepted at M+1 at the earliest. This gives 1 op per `SETTLE_CYCLES`+2 cycles with zero stall.
- **Simultaneous events:**
  - `req_valid` during DONE is not accepted, even when `rsp_ready`=1 on the same edge.
  - `rsp_ready` outside DONE is ignored.
- **Backpressure:** DONE holds indefinitely; `rsp_s`/`rsp_cout` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- `SETTLE_CYCLES`=1: capture occurs on the edge immediately after accept (N+1).

## Test plan
All scenarios use a bench stub driving `alu_s`/`alu_cout`.

- **Reset:** hold `rst` 2 cycles mid-traffic -> all outputs 0, `rsp_valid`=0, `req_ready`=1 on the first cycle after release.
- **Basic op** (`SETTLE_CYCLES`=4): accept at N with a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=0, op=2'b00.
  - From N: `alu_a`=all ones, `alu_b`=0, `alu_cin`=0, `alu_op`=0.
  - Stub drives `alu_s`=64'h0123_4567_89AB_CDEF, `alu_cout`=1 -> `rsp_valid` rises at N+4 with those values.
  - Stub changes `alu_s` at N+5 -> `rsp_s` unchanged.
- **Chain:**
  - Op 1 captures `cout`=1; op 2 with `req_chain`=1, `req_cin`=0 -> `alu_cin`=1.
  - Op 2 captures `cout`=0; op 3 chained with `req_cin`=1 -> `alu_cin`=0.
- **Backpressure:** `rsp_ready`=0 for 10 cycles while `req_valid`=1 with new operands.
  - `rsp_valid`, `rsp_s`, `rsp_cout` stable; `req_ready`=0; `alu_a` unchanged.
  - After `rsp_ready`, the pending request is accepted exactly 1 cycle later.
- **Reset in SETTLE:** `rst` at N+2 -> `rsp_valid` never asserts; a following chained request drives `alu_cin`=0 even after a prior `cout`=1.
- **`SETTLE_CYCLES`=1 instance:** accept at N -> capture and `rsp_valid` at N+1; back-to-back with `rsp_ready`=1 gives one response every 3 cycles.
